// File: rtl/seg7_scan_controller.sv
// Scans eight stored hex digits onto a seven-segment decoder's num/sel inputs.
// Each slot opens with a blanking guard window; digit_mask blanks individual digits.
module seg7_scan_controller #(
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_TICKS     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_mask,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       blank,
  output logic       frame_done
);

  typedef enum logic [1:0] {StIdle, StGuard, StShow} state_e;

  localparam int unsigned CntW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(TICKS_PER_DIGIT - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(BLANK_TICKS - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  // With no guard window every slot opens directly in SHOW.
  localparam state_e SlotStart = (BLANK_TICKS == 0) ? StShow : StGuard;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      sel_q;
  logic [2:0]      sel_nxt;
  logic            blank_q;
  logic            frame_done_q;
  logic [3:0]      mem [8];

  assign sel_nxt = sel_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (!en) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        sel_q   <= 3'd0;
        blank_q <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= SlotStart;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            blank_q <= (BLANK_TICKS == 0) ? ~digit_mask[0] : 1'b1;
          end
          StGuard: begin
            cnt_q <= cnt_q + CntOne;
            if (cnt_q == GuardLast) begin
              state_q <= StShow;
              blank_q <= ~digit_mask[sel_q];
            end else begin
              blank_q <= 1'b1;
            end
          end
          StShow: begin
            if (cnt_q == CntLast) begin
              cnt_q        <= '0;
              sel_q        <= sel_nxt;
              state_q      <= SlotStart;
              blank_q      <= (BLANK_TICKS == 0) ? ~digit_mask[sel_nxt] : 1'b1;
              frame_done_q <= (sel_q == 3'd7);
            end else begin
              cnt_q   <= cnt_q + CntOne;
              blank_q <= ~digit_mask[sel_q];
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            blank_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign num        = mem[sel_q];
  assign sel        = sel_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench: a time-since-enable model predicts every cycle of two scanners,
// one with a 1-cycle guard window and one without.
module tb_seg7_scan_controller;

  localparam int T = 4;
  localparam int B = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic [7:0] digit_mask = 8'hFF;

  logic [3:0] num, num_ng;
  logic [2:0] sel, sel_ng;
  logic       blank, blank_ng;
  logic       frame_done, frame_done_ng;

  seg7_scan_controller #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .digit_mask(digit_mask), .num(num), .sel(sel),
    .blank(blank), .frame_done(frame_done)
  );

  seg7_scan_controller #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(0)) dut_ng (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .digit_mask(digit_mask), .num(num_ng), .sel(sel_ng),
    .blank(blank_ng), .frame_done(frame_done_ng)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] num;
    logic       blank;
    logic       blank_ng;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0] m_mem [8];
  bit         m_active;
  int         m_t;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: cycles elapsed since the scan started determine slot, position and wrap.
  always @(posedge clk) begin
    exp_t e;
    int   slot, pos;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
      m_active = 1'b0;
      m_t      = 0;
    end else begin
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (!en) begin
        m_active = 1'b0;
        m_t      = 0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
      end else begin
        m_t++;
      end
      if (m_active) begin
        slot       = m_t / T;
        pos        = m_t % T;
        e.sel      = 3'(slot % 8);
        e.blank    = (pos < B) ? 1'b1 : !digit_mask[e.sel];
        e.blank_ng = !digit_mask[e.sel];
        e.fd       = (m_t > 0) && (pos == 0) && (e.sel == 3'd0);
      end else begin
        e.sel      = 3'd0;
        e.blank    = 1'b1;
        e.blank_ng = 1'b1;
        e.fd       = 1'b0;
      end
      e.num = m_mem[e.sel];
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sel", 8'(sel), 8'(e.sel));
      check("num", 8'(num), 8'(e.num));
      check("blank", 8'(blank), 8'(e.blank));
      check("frame_done", 8'(frame_done), 8'(e.fd));
      check("sel_ng", 8'(sel_ng), 8'(e.sel));
      check("num_ng", 8'(num_ng), 8'(e.num));
      check("blank_ng", 8'(blank_ng), 8'(e.blank_ng));
      check("frame_done_ng", 8'(frame_done_ng), 8'(e.fd));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Returns just after the negedge where sel first reads s.
  task automatic wait_sel(input logic [2:0] s);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1;
      if (sel == s) found = 1'b1;
    end
    check("wait_sel", 8'(found), 8'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, 8'(sel), 8'd0);
    check({tag, "_num"}, 8'(num), 8'd0);
    check({tag, "_blank"}, 8'(blank), 8'd1);
    check({tag, "_fd"}, 8'(frame_done), 8'd0);
    check({tag, "_sel_ng"}, 8'(sel_ng), 8'd0);
    check({tag, "_blank_ng"}, 8'(blank_ng), 8'd1);
  endtask

  initial begin
    cycles(3);
    check_reset_outputs("por");
    rst_n = 1'b1;
    cycles(3);

    // Load digits i+8 while idle, then scan with all digits enabled.
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 4'(i + 8);
      cycles(1);
    end
    wr_en = 1'b0;
    en    = 1'b1;
    cycles(80);

    digit_mask = 8'b1010_0101;
    cycles(40);
    digit_mask = 8'hFF;

    // Live write into the digit being shown.
    wait_sel(3'd2);
    cycles(1);
    wr_en   = 1'b1;
    wr_addr = 3'd2;
    wr_data = 4'hC;
    cycles(1);
    wr_en = 1'b0;
    cycles(12);

    // Random writes, including ones landing on slot-change edges, plus mask flicker.
    for (int i = 0; i < 48; i++) begin
      wr_en      = 1'($urandom_range(1));
      wr_addr    = 3'($urandom_range(7));
      wr_data    = 4'($urandom_range(15));
      digit_mask = 8'($urandom_range(255));
      cycles(1);
    end
    wr_en      = 1'b0;
    digit_mask = 8'hFF;

    // Enable drop at digit 3, one idle cycle, restart.
    wait_sel(3'd3);
    en = 1'b0;
    cycles(1);
    en = 1'b1;
    cycles(40);

    // Drop enable exactly on the 7->0 wrap edge.
    wait_sel(3'd7);
    cycles(T - 1);
    en = 1'b0;
    cycles(2);
    en = 1'b1;
    cycles(40);

    // Randomly toggled enable.
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(15) != 0);
      cycles(1);
    end
    en = 1'b1;
    cycles(20);

    // Asynchronous reset mid-slot (sel=5, cnt=2).
    wait_sel(3'd5);
    cycles(2);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("async_rst");
    en = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(6);
    check_reset_outputs("post_rst_idle");
    en = 1'b1;
    cycles(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
